// File: rtl/rv64i_pkg.sv
// Shared types and constants for the rv64i instruction-memory responder.
package rv64i_pkg;

    localparam int INSN_W = 32;
    localparam logic [INSN_W-1:0] RV_NOP_INSN = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } imem_state_t;

endpackage

// File: rtl/rv64i_imem_array.sv
// Instruction storage: one write port, combinational read by word index, no reset.
module rv64i_imem_array
    import rv64i_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [INSN_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [INSN_W-1:0] rdata
);

    logic [INSN_W-1:0] mem_r [DEPTH_WORDS];

    // Program-load write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/rv64i_imem_responder.sv
// Fetch responder for the IF stage: one outstanding request, fixed wait states.
// Optional performance counters are enabled with the RV_IMEM_PERF_CNT_EN macro.
module rv64i_imem_responder
    import rv64i_pkg::*;
#(
    parameter int unsigned       DEPTH_WORDS = 1024,
    parameter int unsigned       WAIT_CYCLES = 1,
    parameter logic [INSN_W-1:0] NOP_INSN    = RV_NOP_INSN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req_valid,
    output logic              fetch_req_ready,
    input  logic [63:0]       fetch_req_addr,
    output logic              fetch_rsp_valid,
    input  logic              fetch_rsp_ready,
    output logic [INSN_W-1:0] fetch_rsp_data,
    output logic              fetch_rsp_err,
    input  logic              load_we,
    input  logic [63:0]       load_addr,
    input  logic [INSN_W-1:0] load_data,
    output logic              busy
`ifdef RV_IMEM_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES - 1);

    function automatic logic addr_bad(input logic [63:0] a);
        return (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 64'd0);
    endfunction

    imem_state_t       state_r;
    logic [63:0]       addr_r;
    logic [3:0]        cnt_r;
    logic [63:0]       rd_addr_s;
    logic              rd_bad_s;
    logic              load_ok_s;
    logic              accept_s;
    logic [INSN_W-1:0] mem_rd_s;
    logic [INSN_W-1:0] rsp_data_s;

    // The read address is the live request in IDLE (zero-wait path), else the latched PC
    assign rd_addr_s = (state_r == IDLE) ? fetch_req_addr : addr_r;
    assign rd_bad_s  = addr_bad(rd_addr_s);
    assign load_ok_s = load_we && !addr_bad(load_addr);
    assign accept_s  = fetch_req_valid && fetch_req_ready;

    rv64i_imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .we    (load_ok_s),
        .waddr (load_addr[AW+1:2]),
        .wdata (load_data),
        .raddr (rd_addr_s[AW+1:2]),
        .rdata (mem_rd_s)
    );

    // Response word: NOP on error, same-cycle load forwarded ahead of the array
    always_comb begin
        rsp_data_s = mem_rd_s;
        if (rd_bad_s) begin
            rsp_data_s = NOP_INSN;
        end else if (load_ok_s && (load_addr[AW+1:2] == rd_addr_s[AW+1:2])) begin
            rsp_data_s = load_data;
        end else begin
            rsp_data_s = mem_rd_s;
        end
    end

    // Loads win over fetch acceptance; never ready while in reset
    always_comb begin
        if ((state_r == IDLE) && !load_we && !reset) begin
            fetch_req_ready = 1'b1;
        end else begin
            fetch_req_ready = 1'b0;
        end
    end

    // Fetch FSM with registered response outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= IDLE;
            addr_r          <= 64'd0;
            cnt_r           <= 4'd0;
            fetch_rsp_valid <= 1'b0;
            fetch_rsp_data  <= '0;
            fetch_rsp_err   <= 1'b0;
            busy            <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        addr_r <= fetch_req_addr;
                        busy   <= 1'b1;
                        if (WAIT_CYCLES == 32'd0) begin
                            state_r         <= RESP;
                            fetch_rsp_valid <= 1'b1;
                            fetch_rsp_data  <= rsp_data_s;
                            fetch_rsp_err   <= rd_bad_s;
                        end else begin
                            state_r <= WAIT;
                            cnt_r   <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r         <= RESP;
                        fetch_rsp_valid <= 1'b1;
                        fetch_rsp_data  <= rsp_data_s;
                        fetch_rsp_err   <= rd_bad_s;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                RESP: begin
                    if (fetch_rsp_ready) begin
                        state_r         <= IDLE;
                        fetch_rsp_valid <= 1'b0;
                        busy            <= 1'b0;
                    end
                end
                default: begin
                    state_r         <= IDLE;
                    fetch_rsp_valid <= 1'b0;
                    busy            <= 1'b0;
                end
            endcase
        end
    end

`ifdef RV_IMEM_PERF_CNT_EN
    // Completed-fetch and blocked-request cycle counters, free-running with wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_cnt <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            if (fetch_rsp_valid && fetch_rsp_ready) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (fetch_req_valid && !fetch_req_ready) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rv64i_imem_responder.sv
// Scoreboard bench for rv64i_imem_responder: driver pushes expected responses,
// a forked monitor checks every presented response, its latency and stability.
module tb_rv64i_imem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned W     = 3;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req_valid;
    logic        fetch_req_ready;
    logic [63:0] fetch_req_addr;
    logic        fetch_rsp_valid;
    logic        fetch_rsp_ready;
    logic [31:0] fetch_rsp_data;
    logic        fetch_rsp_err;
    logic        load_we;
    logic [63:0] load_addr;
    logic [31:0] load_data;
    logic        busy;
`ifdef RV_IMEM_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
    int unsigned exp_fetch;
    int unsigned exp_stall;
`endif

    int          checks;
    int          errors;
    logic [31:0] model_mem [DEPTH];
    bit          written   [DEPTH];
    logic [63:0] loaded_q[$];
    logic [32:0] exp_q[$];
    int          acc_q[$];
    int          rd_n;
    int          ncyc;
    bit          in_rsp;

    rv64i_imem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (W),
        .NOP_INSN    (NOP)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_req_valid (fetch_req_valid),
        .fetch_req_ready (fetch_req_ready),
        .fetch_req_addr  (fetch_req_addr),
        .fetch_rsp_valid (fetch_rsp_valid),
        .fetch_rsp_ready (fetch_rsp_ready),
        .fetch_rsp_data  (fetch_rsp_data),
        .fetch_rsp_err   (fetch_rsp_err),
        .load_we         (load_we),
        .load_addr       (load_addr),
        .load_data       (load_data),
        .busy            (busy)
`ifdef RV_IMEM_PERF_CNT_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic bit bad_addr(input logic [63:0] a);
        return (a[1:0] != 2'b00) || (a >= 64'(DEPTH * 4));
    endfunction

    // Reference: {err, data} a fetch of this byte address must return
    function automatic logic [32:0] ref_rsp(input logic [63:0] a);
        if (bad_addr(a)) return {1'b1, NOP};
        return {1'b0, model_mem[int'(a >> 2)]};
    endfunction

    task automatic model_write(input logic [63:0] a, input logic [31:0] d);
        if (!bad_addr(a)) begin
            model_mem[int'(a >> 2)] = d;
            if (!written[int'(a >> 2)]) begin
                written[int'(a >> 2)] = 1'b1;
                loaded_q.push_back(a);
            end
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [63:0] a, input logic [31:0] d);
        load_we   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_we = 1'b0;
        model_write(a, d);
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 80 && (rd_n < exp_q.size() || busy); i++) tick();
        if (i >= 80) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: pending %0d responses", exp_q.size() - rd_n);
        end
    endtask

    // ld_phase: 0 none, 1 load ld_k cycles into WAIT, 2 load at hold cycle ld_k in RESP
    task automatic do_fetch(input logic [63:0] a, input int hold, input int ld_phase,
                            input int ld_k, input logic [63:0] ld_a, input logic [31:0] ld_d);
        bit ok = 1'b0;
        int i;
        fetch_req_valid = 1'b1;
        fetch_req_addr  = a;
        for (i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = fetch_req_ready;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: ready stayed 0 for addr %h", a);
            fetch_req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (ld_phase == 1) model_write(ld_a, ld_d);
        exp_q.push_back(ref_rsp(a));
        #1;
        fetch_req_valid = 1'b0;
        fetch_req_addr  = {$urandom, $urandom};
        if (hold > 0) fetch_rsp_ready = 1'b0;
        if (ld_phase == 1) begin
            repeat (ld_k) tick();
            load_we   = 1'b1;
            load_addr = ld_a;
            load_data = ld_d;
            tick();
            load_we = 1'b0;
        end
        if (hold > 0) begin
            for (i = 0; i < 40 && !fetch_rsp_valid; i++) tick();
            for (int h = 0; h < hold; h++) begin
                if (ld_phase == 2 && h == ld_k) do_load(ld_a, ld_d);
                else tick();
            end
            fetch_rsp_ready = 1'b1;
        end
        wait_done();
    endtask

    // Load coincident with a fetch request: two blocked cycles, then accepted
    task automatic load_block_test(input logic [63:0] a, input logic [31:0] d);
        fetch_req_valid = 1'b1;
        fetch_req_addr  = a;
        load_we   = 1'b1;
        load_addr = a;
        load_data = d;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("ready_blocked_by_load", 64'(fetch_req_ready), 64'd0);
            check("busy_while_blocked", 64'(busy), 64'd0);
            @(posedge clk);
            #1;
        end
        load_we = 1'b0;
        model_write(a, d);
        @(negedge clk);
        check("ready_after_load", 64'(fetch_req_ready), 64'd1);
        @(posedge clk);
        exp_q.push_back(ref_rsp(a));
        #1;
        fetch_req_valid = 1'b0;
        wait_done();
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] la;
        int          hold;
        int          ph;
        int          k;
        int          lat;

        checks = 0;
        errors = 0;
        rd_n   = 0;
        ncyc   = 0;
        in_rsp = 1'b0;
        reset           = 1'b1;
        fetch_req_valid = 1'b0;
        fetch_req_addr  = 64'd0;
        fetch_rsp_ready = 1'b1;
        load_we         = 1'b0;
        load_addr       = 64'd0;
        load_data       = 32'd0;

        fork
            forever begin
                @(negedge clk);
                ncyc++;
                if (reset) begin
                    rd_n   = exp_q.size();
                    in_rsp = 1'b0;
                    acc_q.delete();
`ifdef RV_IMEM_PERF_CNT_EN
                    exp_fetch = 0;
                    exp_stall = 0;
`endif
                end else begin
`ifdef RV_IMEM_PERF_CNT_EN
                    if (fetch_req_valid && !fetch_req_ready) exp_stall++;
                    if (fetch_rsp_valid && fetch_rsp_ready) exp_fetch++;
`endif
                    if (fetch_req_valid && fetch_req_ready) acc_q.push_back(ncyc);
                    if (fetch_rsp_valid) begin
                        if (rd_n >= exp_q.size()) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_rsp: data %h err %0d", fetch_rsp_data, fetch_rsp_err);
                        end else begin
                            if (!in_rsp) begin
                                in_rsp = 1'b1;
                                lat = (acc_q.size() == 0) ? -1 : ncyc - acc_q.pop_front();
                                check("latency", 64'(lat), 64'(W + 1));
                            end
                            check("rsp_err_data", 64'({fetch_rsp_err, fetch_rsp_data}), 64'(exp_q[rd_n]));
                            if (fetch_rsp_ready) begin
                                rd_n++;
                                in_rsp = 1'b0;
                            end
                        end
                    end
                end
            end
        join_none

        tick();
        @(negedge clk);
        check("reset_ready", 64'(fetch_req_ready), 64'd0);
        check("reset_rsp_valid", 64'(fetch_rsp_valid), 64'd0);
        check("reset_rsp_data", 64'(fetch_rsp_data), 64'd0);
        check("reset_rsp_err", 64'(fetch_rsp_err), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(fetch_req_ready), 64'd1);
        tick();

        // Directed: basic fetches, errors, top-of-range word
        do_load(64'h4, 32'h00010013);
        do_load(64'h8, 32'h00020023);
        do_load(64'(DEPTH * 4 - 4), 32'hCAFE0001);
        do_fetch(64'h4, 0, 0, 0, 64'h0, 32'h0);
        do_fetch(64'h8, 0, 0, 0, 64'h0, 32'h0);
        do_fetch(64'h6, 0, 0, 0, 64'h0, 32'h0);
        do_fetch(64'h1000, 0, 0, 0, 64'h0, 32'h0);
        do_fetch(64'(DEPTH * 4 - 4), 0, 0, 0, 64'h0, 32'h0);
        do_load(64'h5, 32'hBAD0BAD0);
        do_fetch(64'h4, 0, 0, 0, 64'h0, 32'h0);

        // Held response with a load to the same word during RESP
        do_fetch(64'h4, 5, 2, 2, 64'h4, 32'hDEADBEEF);
        do_fetch(64'h4, 0, 0, 0, 64'h0, 32'h0);

        // Load during the last WAIT cycle is forwarded into the response
        do_fetch(64'h8, 0, 1, W - 1, 64'h8, 32'h11223344);
        load_block_test(64'h10, 32'h00500513);

        // Randomised traffic
        for (int i = 0; i < 8; i++) do_load(64'($urandom_range(0, DEPTH - 1)) * 64'd4, $urandom);
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 4) == 0)
                    do_load((64'($urandom_range(0, DEPTH - 1)) * 64'd4) | 64'($urandom_range(1, 3)), $urandom);
                else
                    do_load(64'($urandom_range(0, DEPTH - 1)) * 64'd4, $urandom);
            end
            case ($urandom_range(0, 3))
                0, 1:    a = loaded_q[$urandom_range(0, loaded_q.size() - 1)];
                2:       a = loaded_q[$urandom_range(0, loaded_q.size() - 1)] | 64'($urandom_range(1, 3));
                default: a = 64'(DEPTH * 4) + 64'($urandom_range(0, 255)) * 64'd4;
            endcase
            hold = $urandom_range(0, 2);
            ph   = $urandom_range(0, 2);
            if (ph == 2 && hold == 0) ph = 0;
            k  = (ph == 1) ? $urandom_range(0, W - 1) : ((ph == 2) ? $urandom_range(0, hold - 1) : 0);
            la = ($urandom_range(0, 1) == 0) ? a : loaded_q[$urandom_range(0, loaded_q.size() - 1)];
            do_fetch(a, hold, ph, k, la, $urandom);
        end

        // Reset in the second WAIT cycle discards the transaction
        fetch_req_valid = 1'b1;
        fetch_req_addr  = 64'h4;
        @(negedge clk);
        check("ready_before_reset_test", 64'(fetch_req_ready), 64'd1);
        @(posedge clk);
        exp_q.push_back(ref_rsp(64'h4));
        #1;
        fetch_req_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("busy_after_mid_reset", 64'(busy), 64'd0);
        check("rsp_valid_after_mid_reset", 64'(fetch_rsp_valid), 64'd0);
        repeat (W + 4) tick();
        do_fetch(64'h4, 0, 0, 0, 64'h0, 32'h0);
        do_fetch(64'h8, 1, 0, 0, 64'h0, 32'h0);
        load_block_test(64'h14, 32'h00a00593);
        do_fetch(64'h14, 0, 0, 0, 64'h0, 32'h0);
        repeat (3) tick();

`ifdef RV_IMEM_PERF_CNT_EN
        check("perf_fetch_cnt", 64'(perf_fetch_cnt), 64'(exp_fetch));
        check("perf_stall_cnt", 64'(perf_stall_cnt), 64'(exp_stall));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
